// File: rtl/load_store_unit.sv
// Halfword/byte load-store unit in front of a 16-bit word memory with registered reads.
// Accepts one request at a time; SB performs a read-merge-write so only the addressed byte changes.
module load_store_unit #(
  parameter bit ENDIAN_LE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [2:0]  resp_rd,
  output logic        resp_misalign,
  output logic        resp_illegal,
  output logic [15:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [15:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, MERGE, REPLY} state_t;

  localparam logic [2:0] OP_LH  = 3'd0;
  localparam logic [2:0] OP_SH  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  state_t      state, next_state;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [2:0]  rd_q;
  logic [15:0] result_q;

  logic        rd_en, wr_en;
  logic        in_illegal, in_misalign;
  logic        q_illegal, q_misalign;
  logic        sel_hi;
  logic [7:0]  sel_byte;
  logic [15:0] load_result;
  logic [15:0] merged;

  assign req_ready = (state == IDLE) && !rst;

  assign in_illegal  = req_op > OP_SB;
  assign in_misalign = ((req_op == OP_LH) || (req_op == OP_SH)) && req_addr[0];
  assign q_illegal   = op_q > OP_SB;
  assign q_misalign  = ((op_q == OP_LH) || (op_q == OP_SH)) && addr_q[0];

  // sel_hi: the addressed byte lives in bits [15:8] of the word
  assign sel_hi   = ENDIAN_LE ? addr_q[0] : !addr_q[0];
  assign sel_byte = sel_hi ? mem_read_data[15:8] : mem_read_data[7:0];
  assign merged   = sel_hi ? {wdata_q[7:0], mem_read_data[7:0]}
                           : {mem_read_data[15:8], wdata_q[7:0]};

  always_comb begin
    load_result = 16'h0000;
    case (op_q)
      OP_LH:   load_result = mem_read_data;
      OP_LB:   load_result = {{8{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_result = {8'h00, sel_byte};
      default: load_result = 16'h0000;
    endcase
  end

  always_comb begin
    next_state     = state;
    rd_en          = 1'b0;
    wr_en          = 1'b0;
    mem_write_data = 16'h0000;
    case (state)
      IDLE: begin
        if (req_valid && req_ready)
          next_state = (in_illegal || in_misalign) ? REPLY : ACCESS;
      end
      ACCESS: begin
        if (op_q == OP_SH) begin
          wr_en          = 1'b1;
          mem_write_data = wdata_q;
          next_state     = REPLY;
        end else begin
          rd_en      = 1'b1;
          next_state = (op_q == OP_SB) ? MERGE : CAPTURE;
        end
      end
      CAPTURE: next_state = REPLY;
      MERGE: begin
        wr_en          = 1'b1;
        mem_write_data = merged;
        next_state     = REPLY;
      end
      REPLY:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gating with rst kills an in-flight write without waiting for a clock edge
  assign mem_read    = rd_en && !rst;
  assign mem_write   = wr_en && !rst;
  assign mem_address = {addr_q[15:1], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= 3'd0;
      addr_q        <= 16'h0000;
      wdata_q       <= 16'h0000;
      rd_q          <= 3'd0;
      result_q      <= 16'h0000;
      resp_valid    <= 1'b0;
      resp_data     <= 16'h0000;
      resp_rd       <= 3'd0;
      resp_misalign <= 1'b0;
      resp_illegal  <= 1'b0;
    end else begin
      state <= next_state;
      if (req_valid && req_ready) begin
        op_q     <= req_op;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        result_q <= 16'h0000;
      end
      if (state == CAPTURE)
        result_q <= load_result;
      resp_valid    <= (state == REPLY);
      resp_misalign <= (state == REPLY) && q_misalign;
      resp_illegal  <= (state == REPLY) && q_illegal;
      if (state == REPLY) begin
        resp_data <= result_q;
        resp_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [2:0]  resp_rd;
  logic        resp_misalign;
  logic        resp_illegal;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_read_data;

  load_store_unit #(.ENDIAN_LE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .resp_misalign(resp_misalign), .resp_illegal(resp_illegal),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word memory seen by the DUT: write-first, registered read
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[15:1]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem_write ? mem_write_data : mem[mem_address[15:1]];
  end

  int          wr_count = 0;
  int          rd_count = 0;
  logic [15:0] last_wdata = 16'h0000;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_count   = wr_count + 1;
      last_wdata = mem_write_data;
    end
    if (mem_read) rd_count = rd_count + 1;
  end

  // Reference: what each op should do to the word array, from the op semantics alone
  task automatic model(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] data, output logic mis, output logic ill,
                       output int lat, output int nrd, output int nwr, output logic [15:0] wval);
    int          widx;
    logic [15:0] word;
    logic [15:0] b;
    widx = int'(addr >> 1);
    word = ref_mem[widx];
    b    = addr[0] ? (word >> 8) : (word & 16'h00FF);
    data = 16'h0000; mis = 1'b0; ill = 1'b0; nrd = 0; nwr = 0; wval = 16'h0000; lat = 1;
    if (op > 3'd4) ill = 1'b1;
    else if ((op == 3'd0 || op == 3'd1) && addr[0]) mis = 1'b1;
    else begin
      case (op)
        3'd0: begin data = word; lat = 3; nrd = 1; end
        3'd1: begin ref_mem[widx] = wdata; wval = wdata; lat = 2; nwr = 1; end
        3'd2: begin data = (b >= 16'd128) ? (b | 16'hFF00) : b; lat = 3; nrd = 1; end
        3'd3: begin data = b; lat = 3; nrd = 1; end
        default: begin
          wval = addr[0] ? ((word & 16'h00FF) | ((wdata & 16'h00FF) << 8))
                         : ((word & 16'hFF00) | (wdata & 16'h00FF));
          ref_mem[widx] = wval;
          lat = 3; nrd = 1; nwr = 1;
        end
      endcase
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input string tag, input logic [2:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [2:0] rd, output logic [15:0] got);
    logic [15:0] e_data, e_wval;
    logic        e_mis, e_ill;
    int          e_lat, e_nrd, e_nwr, r0, w0, lat;
    model(op, addr, wdata, e_data, e_mis, e_ill, e_lat, e_nrd, e_nwr, e_wval);
    @(negedge clk);
    r0 = rd_count; w0 = wr_count;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    wait_ready(tag);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom); req_rd = 3'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 10);
    got = resp_data;
    check_val({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check_val({tag, "_data"}, 32'(resp_data), 32'(e_data));
    check_val({tag, "_rd"}, 32'(resp_rd), 32'(rd));
    check_val({tag, "_misalign"}, 32'(resp_misalign), 32'(e_mis));
    check_val({tag, "_illegal"}, 32'(resp_illegal), 32'(e_ill));
    check_val({tag, "_reads"}, 32'(rd_count - r0), 32'(e_nrd));
    check_val({tag, "_writes"}, 32'(wr_count - w0), 32'(e_nwr));
    if (e_nwr != 0) check_val({tag, "_wdata"}, 32'(last_wdata), 32'(e_wval));
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check_val({tag, "_hold"}, 32'(resp_data), 32'(e_data));
    check_val({tag, "_flags_clear"}, 32'({resp_misalign, resp_illegal}), 32'd0);
  endtask

  logic [15:0] got;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0000; req_wdata = 16'h0000; req_rd = 3'd0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[8] = 16'hA5C3;
    ref_mem[8] = 16'hA5C3;

    #1;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_outputs", 32'({resp_valid, resp_misalign, resp_illegal, mem_read, mem_write}), 32'd0);
    check_val("rst_resp", 32'({resp_data, resp_rd}), 32'd0);
    repeat (3) @(negedge clk);
    check_val("rst_ready_held", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst_release_ready", 32'(req_ready), 32'd1);

    run_req("lh_a5c3", 3'd0, 16'h0010, 16'h1234, 3'd5, got);
    check_val("lh_a5c3_const", 32'(got), 32'h0000A5C3);
    run_req("lb_hi", 3'd2, 16'h0011, 16'h0000, 3'd1, got);
    check_val("lb_hi_const", 32'(got), 32'h0000FFA5);
    run_req("lbu_lo", 3'd3, 16'h0010, 16'h0000, 3'd2, got);
    check_val("lbu_lo_const", 32'(got), 32'h000000C3);
    run_req("sb_hi", 3'd4, 16'h0011, 16'h007E, 3'd3, got);
    check_val("sb_hi_wdata_const", 32'(last_wdata), 32'h00007EC3);
    run_req("lh_after_sb", 3'd0, 16'h0010, 16'h0000, 3'd4, got);
    check_val("lh_after_sb_const", 32'(got), 32'h00007EC3);
    run_req("sh_misalign", 3'd1, 16'h0021, 16'hBEEF, 3'd6, got);
    run_req("illegal_op6", 3'd6, 16'h0022, 16'hBEEF, 3'd7, got);
    run_req("lb_odd_ok", 3'd2, 16'h0021, 16'h0000, 3'd0, got);

    // Reset in the ACCESS cycle of an SB: the merge write must never happen
    begin
      int w0;
      @(negedge clk);
      w0 = wr_count;
      req_valid = 1'b1; req_op = 3'd4; req_addr = 16'h0031; req_wdata = 16'h0055; req_rd = 3'd1;
      wait_ready("sb_rst");
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_val("sb_rst_mem_idle", 32'({mem_read, mem_write}), 32'd0);
      check_val("sb_rst_resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      check_val("sb_rst_ready_low", 32'(req_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("sb_rst_ready_high", 32'(req_ready), 32'd1);
      check_val("sb_rst_no_write", 32'(wr_count - w0), 32'd0);
    end
    run_req("lh_after_rst", 3'd0, 16'h0030, 16'h0000, 3'd2, got);

    // Back-to-back SH then LH with req_valid held high
    begin
      logic [15:0] e_data, e_wval;
      logic        e_mis, e_ill;
      int          e_lat, e_nrd, e_nwr, gap, lat;
      logic        rdy;
      model(3'd1, 16'h0040, 16'h3C5A, e_data, e_mis, e_ill, e_lat, e_nrd, e_nwr, e_wval);
      model(3'd0, 16'h0040, 16'h0000, e_data, e_mis, e_ill, e_lat, e_nrd, e_nwr, e_wval);
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd1; req_addr = 16'h0040; req_wdata = 16'h3C5A; req_rd = 3'd3;
      wait_ready("b2b");
      @(posedge clk);
      #1;
      req_op = 3'd0; req_rd = 3'd6; req_wdata = 16'h0000;
      gap = 0;
      do begin
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
        gap++;
        if (gap == 2) check_val("b2b_sh_resp", 32'(resp_valid), 32'd1);
      end while (!rdy && gap < 10);
      req_valid = 1'b0;
      check_val("b2b_gap", 32'(gap), 32'd3);
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!resp_valid && lat < 10);
      check_val("b2b_lh_latency", 32'(lat), 32'd3);
      check_val("b2b_lh_data", 32'(resp_data), 32'(e_data));
      check_val("b2b_lh_const", 32'(resp_data), 32'h00003C5A);
      check_val("b2b_lh_rd", 32'(resp_rd), 32'd6);
    end

    for (int k = 0; k < 80; k++) begin
      run_req("rand", 3'($urandom_range(0, 7)), 16'($urandom_range(0, 255)),
              16'($urandom), 3'($urandom), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ENDIAN_LE, default 1, 1 = addr[0]=0 selects bits [7:0]; 0 = addr[0]=0 selects bits [15:8].
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  in  1  request present.
REQ-005 SHALL have port: req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port: req_op  in  3  0=LH, 1=SH, 2=LB, 3=LBU, 4=SB, 5-7 illegal.
REQ-007 SHALL have port: req_addr  in  16  byte address.
REQ-008 SHALL have port: req_wdata  in  16  store data; SB uses [7:0].
REQ-009 SHALL have port: req_rd  in  3  destination register tag.
REQ-010 SHALL have port: resp_valid  out  1  one-cycle response pulse.
REQ-011 SHALL have port: resp_data  out  16  load result; 0 for stores and faults.
REQ-012 SHALL have port: resp_rd  out  3  tag echoed from the accepted request.
REQ-013 SHALL have port: resp_misalign  out  1  LH/SH with addr[0]=1.
REQ-014 SHALL have port: resp_illegal  out  1  op 5-7.
REQ-015 SHALL have ports: mem_address out 16, mem_write_data out 16, mem_read out 1, mem_write out 1, mem_read_data in 16; the word memory has write-first/read-registered timing, so mem_read_data is valid the cycle after mem_read.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, CAPTURE, MERGE, REPLY.
REQ-017 SHALL drive req_ready=1 only in IDLE; handshake = req_valid & req_ready; on handshake, op/addr/wdata/rd SHALL be latched.
REQ-018 SHALL drive mem_* combinationally from state plus latched request; mem_address = latched addr with bit 0 cleared.
REQ-019 SHALL hold mem_read=mem_write=0 in IDLE, REPLY, and for faulting requests.
REQ-020 LH/LB/LBU: IDLE -> ACCESS (mem_read=1) -> CAPTURE (sample mem_read_data, form result) -> REPLY; resp_valid SHALL assert 3 cycles after the accept edge.
REQ-021 SH: IDLE -> ACCESS (mem_write=1, mem_write_data=wdata) -> REPLY; resp_valid SHALL assert 2 cycles after accept.
REQ-022 SB: IDLE -> ACCESS (mem_read=1) -> MERGE (mem_write=1, mem_write_data = mem_read_data with the selected byte replaced by wdata[7:0], other byte unchanged) -> REPLY; resp_valid SHALL assert 3 cycles after accept.
REQ-023 LB SHALL sign-extend the selected byte; LBU SHALL zero-extend it; LH SHALL return the full word.
REQ-024 Misaligned LH/SH or illegal op: IDLE -> REPLY with no memory access; resp_valid SHALL assert 1 cycle after accept with the matching flag set and resp_data=0.
REQ-025 Byte ops SHALL never flag misalign at any addr[0].
REQ-026 REPLY SHALL last exactly one cycle and return to IDLE; resp_* SHALL be registered and hold their values until the next response; resp_misalign/resp_illegal SHALL be 0 except on the corresponding response.
REQ-027 No response back-pressure: the consumer SHALL always accept resp_valid; back-to-back requests SHALL be accepted on the cycle after REPLY.
REQ-028 req_* changes while not in IDLE SHALL have no effect.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, mem_read=0, mem_write=0, resp_valid=0, resp_data=0, resp_rd=0, resp_misalign=0, resp_illegal=0, req_ready=0 while rst is held, and req_ready=1 from the first edge after release.
REQ-030 Reset during SB ACCESS SHALL suppress the MERGE write; reset during MERGE SHALL deassert mem_write asynchronously. The write SHALL be lost or completed, never partial at a byte level.

Verification
REQ-031 Preload word 0x0010=0xA5C3; LH addr 0x0010, rd=5 -> resp_valid 3 cycles after accept, resp_data=0xA5C3, resp_rd=5, flags 0.
REQ-032 Same word; LB addr 0x0011 (ENDIAN_LE=1) -> resp_data=0xFFA5; LBU addr 0x0010 -> 0x00C3.
REQ-033 SB addr 0x0011, wdata=0x007E onto 0xA5C3 -> one mem_write in the MERGE cycle with data 0x7EC3; a following LH returns 0x7EC3.
REQ-034 SH addr 0x0021 -> resp_valid 1 cycle after accept, resp_misalign=1, no mem_write pulse, memory unchanged; op=6 -> resp_illegal=1.
REQ-035 Assert rst in the ACCESS cycle of an SB -> no mem_write observed; word unchanged; req_ready=1 on the first edge after release.
REQ-036 Back-to-back SH then LH, req_valid held high -> second accept in the cycle after the first REPLY; the LH returns the SH data.
